keccak_squeeze_ctrl: RTL and testbench
======================================

// Module: keccak_squeeze_ctrl
// PURPOSE
// - Sequences the squeeze phase of the Keccak engine.
// - Owns the bytes-squeezed counter fed to the output unit, and drives a valid/ready output stream.
// - Requests re-permutation when the rate block is drained, and terminates on the fixed digest
//   length (SHA3) or the requested/stopped length (SHAKE XOF).
// - Sits between the main engine FSM, the permutation core and the output unit.
// PARAMETERS
// - DATA_BYTES  32  bytes per output beat; equals MAX_OUTPUT_DWIDTH/8
// - LEN_WIDTH   16  width of the XOF requested-length field, in bytes
// PORTS
// - clk             in   1                  single clock, rising edge
// - rst             in   1                  synchronous, active-high reset
// - start_i         in   1                  pulse: absorb done, state valid, begin squeeze
// - stop_i          in   1                  abort/terminate squeeze (XOF external stop)
// - keccak_mode_i   in   MODE_SEL_WIDTH     mode, sampled on start_i
// - rate_i          in   RATE_WIDTH         rate in bits, sampled on start_i
// - xof_len_i       in   LEN_WIDTH          XOF byte count, sampled on start_i; 0 = unbounded
// - perm_needed_i   in   1                  from output unit: current beat drains rate
// - unit_keep_i     in   DATA_BYTES         from output unit: rate-limited byte mask
// - bytes_sq_o      out  BYTE_ABSORB_WIDTH  counter driven to output unit
// - perm_start_o    out  1                  one-cycle pulse to permutation core
// - perm_done_i     in   1                  permutation complete pulse
// - valid_o         out  1                  output beat valid
// - ready_i         in   1                  downstream accepts beat
// - keep_o          out  DATA_BYTES         final byte mask (rate AND length limited)
// - last_o          out  1                  final beat of digest
// - done_o          out  1                  one-cycle pulse after last beat / stop
// - busy_o          out  1                  state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; bytes_sq_o=0; outputs valid_o/perm_start_o/last_o/done_o/busy_o=0;
//   keep_o=0; internal emitted count=0.
// - FSM states: IDLE, EMIT, PERM, DONE.
// - IDLE -> EMIT on start_i:
//   - latch mode and rate; target = 32 (SHA3_256), 64 (SHA3_512), else xof_len_i.
//   - bytes_sq_o=0, emitted=0.
// - EMIT: valid_o=1; first beat valid the cycle after start_i.
//   - len_rem = target - emitted (unbounded if XOF and target==0).
//   - keep_o = unit_keep_i AND ((1<<min(len_rem,DATA_BYTES))-1).
//   - last_o = bounded AND len_rem <= popcount(unit_keep_i).
// - Beat handshake = valid_o && ready_i; on handshake emitted += popcount(keep_o), then:
//   - last_o -> DONE;
//   - else perm_needed_i -> PERM with perm_start_o=1 that cycle, bytes_sq_o<=0;
//   - else bytes_sq_o += DATA_BYTES.
// - Hold rule: valid_o && !ready_i -> bytes_sq_o, keep_o, last_o stable; valid_o never
//   depends on ready_i.
// - PERM: valid_o=0; wait perm_done_i, then -> EMIT. perm_done_i in any other state is ignored.
// - DONE: done_o=1 for one cycle, -> IDLE.
// - stop_i in EMIT/PERM -> DONE next cycle:
//   - a handshake in the same cycle is counted;
//   - in PERM the permutation is left to finish, its done ignored;
//   - stop_i has no effect in IDLE/DONE.
// - start_i outside IDLE is ignored. Synchronous rst mid-squeeze returns to reset values next edge.
// - Widths:
//   - emitted is LEN_WIDTH+1 bits, saturates at max (unbounded XOF never sets last_o);
//   - bytes_sq_o never exceeds rate_i/8 rounded up to DATA_BYTES.
// - Fixed rates:
//   - SHA3_256 (rate 136 B): 1 beat, no perm.
//   - SHA3_512 (rate 72 B): 2 beats, no perm.
// CONFIGURATION
// - KECCAK_SQUEEZE_STATS_EN defined:
//   - adds outputs beat_cnt_o[15:0] and perm_cnt_o[7:0];
//   - both clear on start_i and rst, increment per handshake / per perm_start_o, saturate at max.
// - Undefined: ports absent, no counters synthesized; all other behaviour identical.
// TESTING
// - SHA3_256, ready_i=1:
//   - start -> one beat, keep_o=32'hFFFF_FFFF, last_o=1, no perm_start_o, done_o 1 cycle later.
// - SHA3_512:
//   - two beats: bytes_sq_o 0 then 32; keep all-ones both; last_o on beat 2 only.
// - SHAKE128, xof_len_i=200:
//   - beats 0..4 full; beat 5 keep=8'hFF (8 B), perm_start_o;
//   - after perm_done_i, beat with bytes_sq_o=0 and 32 B;
//   - final beat keep=32'h0000_0000 -> n/a; total emitted exactly 200; last on 200th byte.
// - Backpressure: ready_i low 5 cycles mid-SHA3_512 -> valid_o held 1, bytes_sq_o/keep_o/last_o
//   stable, no beat lost or duplicated.
// - SHAKE256, xof_len_i=0:
//   - 6 beats: bytes_sq_o 0,32,64,96,128 (keep 8'hFF, perm), then 0;
//   - stop_i with ready_i=1 -> beat counted, done_o pulse, IDLE, last_o never 1.
// - rst asserted in PERM -> next cycle IDLE, all outputs 0; later start_i squeezes from bytes_sq_o=0.

Source files
------------

// File: rtl/keccak_squeeze_ctrl.sv
// Squeeze-phase sequencer for the Keccak engine: beat stream, re-permutation requests, digest length.
// Optional KECCAK_SQUEEZE_STATS_EN adds saturating beat and permutation counters.
module keccak_squeeze_ctrl #(
  parameter int DATA_BYTES        = 32,
  parameter int LEN_WIDTH         = 16,
  parameter int MODE_SEL_WIDTH    = 2,
  parameter int RATE_WIDTH        = 11,
  parameter int BYTE_ABSORB_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic                         stop_i,
  input  logic [MODE_SEL_WIDTH-1:0]    keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic [LEN_WIDTH-1:0]         xof_len_i,
  input  logic                         perm_needed_i,
  input  logic [DATA_BYTES-1:0]        unit_keep_i,
  output logic [BYTE_ABSORB_WIDTH-1:0] bytes_sq_o,
  output logic                         perm_start_o,
  input  logic                         perm_done_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DATA_BYTES-1:0]        keep_o,
  output logic                         last_o,
  output logic                         done_o,
  output logic                         busy_o
`ifdef KECCAK_SQUEEZE_STATS_EN
  ,
  output logic [15:0]                  beat_cnt_o,
  output logic [7:0]                   perm_cnt_o
`endif
);

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(1);
  localparam int CW  = $clog2(DATA_BYTES + 1);
  localparam int RBW = RATE_WIDTH - 2;
  localparam int EW  = LEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EMIT, PERM, DONE} state_t;

  state_t                         state_q, state_d;
  logic [EW-1:0]                  target_q, emitted_q, len_rem;
  logic                           xof_q, bounded;
  logic [RBW-1:0]                 rate_bytes_q;
  logic [RATE_WIDTH:0]            rate_sum;
  logic [RBW:0]                   rate_cap, bytes_inc;
  logic [DATA_BYTES-1:0]          len_mask;
  logic [CW-1:0]                  unit_pop, keep_pop;
  logic [EW:0]                    emitted_sum;
  logic                           hs;

  function automatic logic [CW-1:0] popcount(input logic [DATA_BYTES-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_BYTES; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  // Rate in bits rounded up to whole bytes, then to whole beats, bounds the squeeze pointer.
  assign rate_sum  = {1'b0, rate_i} + (RATE_WIDTH + 1)'(7);
  assign rate_cap  = (({1'b0, rate_bytes_q} + (RBW + 1)'(DATA_BYTES - 1)) / (RBW + 1)'(DATA_BYTES))
                     * (RBW + 1)'(DATA_BYTES);
  assign bytes_inc = (RBW + 1)'(bytes_sq_o) + (RBW + 1)'(DATA_BYTES);

  assign bounded     = !xof_q || (target_q != '0);
  assign len_rem     = target_q - emitted_q;
  assign unit_pop    = popcount(unit_keep_i);
  assign keep_pop    = popcount(keep_o);
  assign emitted_sum = {1'b0, emitted_q} + (EW + 1)'(keep_pop);

  always_comb begin
    len_mask = '1;
    if (bounded && (len_rem < EW'(DATA_BYTES))) begin
      for (int i = 0; i < DATA_BYTES; i++) len_mask[i] = (EW'(i) < len_rem);
    end
  end

  // Next state and stream outputs; a stop wins over a permutation request on the same beat.
  always_comb begin
    state_d      = state_q;
    valid_o      = 1'b0;
    keep_o       = '0;
    last_o       = 1'b0;
    perm_start_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != IDLE);
    hs           = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = EMIT;
      EMIT: begin
        valid_o = 1'b1;
        keep_o  = unit_keep_i & len_mask;
        last_o  = bounded && (len_rem <= EW'(unit_pop));
        hs      = ready_i;
        if (hs && last_o) state_d = DONE;
        else if (stop_i) state_d = DONE;
        else if (hs && perm_needed_i) begin
          state_d      = PERM;
          perm_start_o = 1'b1;
        end
      end
      PERM: begin
        if (stop_i) state_d = DONE;
        else if (perm_done_i) state_d = EMIT;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      emitted_q    <= '0;
      xof_q        <= 1'b0;
      rate_bytes_q <= '0;
      bytes_sq_o   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_i) begin
          xof_q        <= (keccak_mode_i != MODE_SHA3_256) && (keccak_mode_i != MODE_SHA3_512);
          rate_bytes_q <= rate_sum[RATE_WIDTH:3];
          bytes_sq_o   <= '0;
          emitted_q    <= '0;
          if (keccak_mode_i == MODE_SHA3_256)      target_q <= EW'(32);
          else if (keccak_mode_i == MODE_SHA3_512) target_q <= EW'(64);
          else                                     target_q <= EW'(xof_len_i);
        end
        EMIT: if (hs) begin
          emitted_q <= emitted_sum[EW] ? '1 : emitted_sum[EW-1:0];
          if (!last_o && !stop_i) begin
            if (perm_needed_i)             bytes_sq_o <= '0;
            else if (bytes_inc < rate_cap) bytes_sq_o <= BYTE_ABSORB_WIDTH'(bytes_inc);
          end
        end
        DONE: bytes_sq_o <= '0;
        default: ;
      endcase
    end
  end

`ifdef KECCAK_SQUEEZE_STATS_EN
  // Statistics restart with every accepted squeeze and stick at their maximum.
  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start_i)) begin
      beat_cnt_o <= '0;
      perm_cnt_o <= '0;
    end else begin
      if (hs && beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + 16'd1;
      if (perm_start_o && perm_cnt_o != '1) perm_cnt_o <= perm_cnt_o + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// Directed self-checking bench for keccak_squeeze_ctrl, with a behavioural output-unit model.
module tb_keccak_squeeze_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, stop_i, perm_done_i, ready_i;
  logic [1:0]  keccak_mode_i;
  logic [10:0] rate_i;
  logic [15:0] xof_len_i;
  logic        perm_needed_i;
  logic [31:0] unit_keep_i;
  logic [7:0]  bytes_sq_o;
  logic        perm_start_o, valid_o, last_o, done_o, busy_o;
  logic [31:0] keep_o;
`ifdef KECCAK_SQUEEZE_STATS_EN
  logic [15:0] beat_cnt_o;
  logic [7:0]  perm_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int rateBytes = 0;
  int rem;
  int total;

  keccak_squeeze_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .keccak_mode_i(keccak_mode_i), .rate_i(rate_i), .xof_len_i(xof_len_i),
    .perm_needed_i(perm_needed_i), .unit_keep_i(unit_keep_i), .bytes_sq_o(bytes_sq_o),
    .perm_start_o(perm_start_o), .perm_done_i(perm_done_i), .valid_o(valid_o),
    .ready_i(ready_i), .keep_o(keep_o), .last_o(last_o), .done_o(done_o), .busy_o(busy_o)
`ifdef KECCAK_SQUEEZE_STATS_EN
    , .beat_cnt_o(beat_cnt_o), .perm_cnt_o(perm_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Output unit: keep masks the bytes left in the rate block, and a beat that empties it needs a perm.
  always_comb begin
    rem = rateBytes - int'(bytes_sq_o);
    if (rem >= 32)     unit_keep_i = '1;
    else if (rem <= 0) unit_keep_i = '0;
    else               unit_keep_i = (32'h1 << rem) - 32'h1;
    perm_needed_i = (rem <= 32);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic rdy, input logic pd);
    start_i     = s;
    stop_i      = st;
    ready_i     = rdy;
    perm_done_i = pd;
  endtask

  task automatic beginSqueeze(input logic [1:0] mode, input int rateBits, input int len,
                              input logic rdy);
    keccak_mode_i = mode;
    rate_i        = 11'(rateBits);
    xof_len_i     = 16'(len);
    rateBytes     = rateBits / 8;
    applyStimulus(1'b1, 1'b0, rdy, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, rdy, 1'b0);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [7:0] bytes, input logic [31:0] keep,
                           input logic last, input logic perm);
    checkOutput({tag, ".valid"}, 64'(valid_o), 64'd1);
    checkOutput({tag, ".bytes"}, 64'(bytes_sq_o), 64'(bytes));
    checkOutput({tag, ".keep"}, 64'(keep_o), 64'(keep));
    checkOutput({tag, ".last"}, 64'(last_o), 64'(last));
    checkOutput({tag, ".perm"}, 64'(perm_start_o), 64'(perm));
  endtask

  logic [7:0]  beatBytes [6];
  logic [31:0] beatKeep  [6];

  initial begin
    beatBytes = '{8'd0, 8'd32, 8'd64, 8'd96, 8'd128, 8'd160};
    beatKeep  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  32'h0000_00FF};
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    keccak_mode_i = '0;
    rate_i        = '0;
    xof_len_i     = '0;
    rst           = 1'b1;
    tick();
    tick();
    checkOutput("rst.valid", 64'(valid_o), 64'd0);
    checkOutput("rst.busy", 64'(busy_o), 64'd0);
    checkOutput("rst.bytes", 64'(bytes_sq_o), 64'd0);
    checkOutput("rst.keep", 64'(keep_o), 64'd0);
    checkOutput("rst.done", 64'(done_o), 64'd0);
    checkOutput("rst.perm", 64'(perm_start_o), 64'd0);
    rst = 1'b0;

    // SHA3-256: single full beat, then a one-cycle done.
    beginSqueeze(2'd0, 1088, 0, 1'b1);
    checkBeat("s256", 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    checkOutput("s256.done", 64'(done_o), 64'd1);
    checkOutput("s256.valid_off", 64'(valid_o), 64'd0);
    tick();
    checkOutput("s256.done_clr", 64'(done_o), 64'd0);
    checkOutput("s256.idle", 64'(busy_o), 64'd0);

    // SHA3-512 with backpressure on both beats; start_i during the stall is ignored.
    beginSqueeze(2'd1, 576, 0, 1'b0);
    checkBeat("s512.b0", 8'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    checkBeat("s512.b0hold", 8'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkBeat("s512.b1", 8'd32, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkBeat("s512.hold", 8'd32, 32'hFFFF_FFFF, 1'b1, 1'b0);
      checkOutput("s512.hold_done", 64'(done_o), 64'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("s512.done", 64'(done_o), 64'd1);
    tick();
    checkOutput("s512.idle", 64'(busy_o), 64'd0);

    // SHAKE128, 200 bytes: 168 bytes, permutation, then the final 32.
    beginSqueeze(2'd2, 1344, 200, 1'b1);
    total = 0;
    for (int i = 0; i < 6; i++) begin
      checkBeat($sformatf("k128.b%0d", i), beatBytes[i], beatKeep[i], 1'b0, i == 5);
      total += $countones(keep_o);
      tick();
    end
    checkOutput("k128.perm_valid", 64'(valid_o), 64'd0);
    checkOutput("k128.perm_busy", 64'(busy_o), 64'd1);
    tick();
    checkOutput("k128.perm_wait", 64'(valid_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkBeat("k128.b6", 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    total += $countones(keep_o);
    tick();
    checkOutput("k128.done", 64'(done_o), 64'd1);
    checkOutput("k128.total", 64'(total), 64'd200);
`ifdef KECCAK_SQUEEZE_STATS_EN
    checkOutput("k128.beat_cnt", 64'(beat_cnt_o), 64'd7);
    checkOutput("k128.perm_cnt", 64'(perm_cnt_o), 64'd1);
`endif
    tick();
    checkOutput("k128.idle", 64'(busy_o), 64'd0);

    // A stray perm_done_i while idle must not wake the sequencer.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle.perm_done", 64'(busy_o), 64'd0);

    // SHAKE256 unbounded: never last, stop on the post-permutation beat.
    beginSqueeze(2'd3, 1088, 0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkBeat($sformatf("k256.b%0d", i), beatBytes[i], (i == 4) ? 32'h0000_00FF : 32'hFFFF_FFFF,
                1'b0, i == 4);
      tick();
    end
    checkOutput("k256.perm_valid", 64'(valid_o), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkBeat("k256.b5", 8'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("k256.done", 64'(done_o), 64'd1);
    checkOutput("k256.last", 64'(last_o), 64'd0);
    tick();
    checkOutput("k256.idle", 64'(busy_o), 64'd0);

    // Reset while waiting on the permutation, then a fresh squeeze restarts from zero.
    beginSqueeze(2'd3, 1088, 0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rstp.in_perm", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstp.busy", 64'(busy_o), 64'd0);
    checkOutput("rstp.bytes", 64'(bytes_sq_o), 64'd0);
    checkOutput("rstp.valid", 64'(valid_o), 64'd0);
    checkOutput("rstp.done", 64'(done_o), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("idle.stop", 64'(busy_o), 64'd0);
    beginSqueeze(2'd0, 1088, 0, 1'b1);
    checkBeat("again", 8'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    checkOutput("again.done", 64'(done_o), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
